// File: rtl/wts_timer_pkg.sv
// Shared constants for the multi-channel sound-chip timer: channel modes and
// the layout of each channel's 8-bit status byte.
package wts_timer_pkg;

  localparam int STS_W        = 8;
  localparam int STS_PEND_N   = 7;
  localparam int STS_OVF      = 6;
  localparam int STS_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    MODE_EVENT    = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PERIODIC = 2'b10,
    MODE_OFF      = 2'b11
  } mode_e;

  function automatic logic is_countdown(input mode_e m);
    return (m == MODE_ONESHOT) || (m == MODE_PERIODIC);
  endfunction

endpackage

// File: rtl/wts_timer_channel.sv
// One timer channel: countdown counter with running flag, pending/overflow
// flags and captured wave address. Clear beats fire; load beats decrement.
module wts_timer_channel
  import wts_timer_pkg::*;
#(
  parameter int CNT_W  = 12,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              tick_i,
  input  logic              trigger_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  input  logic [CNT_W-1:0]  reload_i,
  input  logic              load_i,
  input  logic              clear_i,
  output logic [STS_W-1:0]  status_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              pending_n_o
);

  mode_e             mode;
  logic              fire;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              pend_n_q, pend_n_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign mode = mode_e'(mode_i);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    fire  = 1'b0;
    // Load is a register write and takes effect regardless of mode/enable.
    if (load_i) begin
      cnt_d = reload_i;
      run_d = (reload_i != '0);
    end else if (enable_i && is_countdown(mode) && tick_i && run_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        fire = 1'b1;
        if (mode == MODE_PERIODIC) cnt_d = reload_i;
        else                       run_d = 1'b0;
      end
    end
    if (enable_i && (mode == MODE_EVENT) && trigger_i) fire = 1'b1;
  end

  always_comb begin
    pend_n_d = pend_n_q;
    ovf_d    = ovf_q;
    addr_d   = addr_q;
    if (clear_i) begin
      pend_n_d = 1'b1;
      ovf_d    = 1'b0;
    end else if (fire) begin
      ovf_d    = ovf_q | ~pend_n_q;
      pend_n_d = 1'b0;
      addr_d   = address_i;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q    <= '0;
      run_q    <= 1'b0;
      pend_n_q <= 1'b1;
      ovf_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      pend_n_q <= pend_n_d;
      ovf_q    <= ovf_d;
      addr_q   <= addr_d;
    end
  end

  always_comb begin
    status_o                              = '0;
    status_o[STS_PEND_N]                  = pend_n_q;
    status_o[STS_OVF]                     = ovf_q;
    status_o[STS_ADDR_LSB +: ADDR_W]      = addr_q;
  end

  assign count_o     = cnt_q;
  assign pending_n_o = pend_n_q;

endmodule

// File: rtl/wts_timer_multi.sv
// NUM_CH-channel timer/interrupt block with a single active-low interrupt.
// Optional per-channel interrupt mask enabled by defining WTS_TIMER_MASK_EN.
module wts_timer_multi
  import wts_timer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 12,
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    tick,
  input  logic [NUM_CH-1:0]       event_trigger,
  input  logic [NUM_CH*ADDR_W-1:0] event_address,
  input  logic [NUM_CH-1:0]       reg_enable,
  input  logic [2*NUM_CH-1:0]     reg_mode,
  input  logic [NUM_CH*CNT_W-1:0] reg_reload,
  input  logic [NUM_CH-1:0]       reg_load,
  input  logic [NUM_CH-1:0]       reg_clear,
`ifdef WTS_TIMER_MASK_EN
  input  logic [NUM_CH-1:0]       reg_int_mask,
`endif
  output logic [STS_W*NUM_CH-1:0] status,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic                    nint
);

  logic [NUM_CH-1:0] pend_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wts_timer_channel #(
      .CNT_W  (CNT_W),
      .ADDR_W (ADDR_W)
    ) u_ch (
      .clk         (clk),
      .nreset      (nreset),
      .tick_i      (tick),
      .trigger_i   (event_trigger[i]),
      .address_i   (event_address[i*ADDR_W +: ADDR_W]),
      .enable_i    (reg_enable[i]),
      .mode_i      (reg_mode[2*i +: 2]),
      .reload_i    (reg_reload[i*CNT_W +: CNT_W]),
      .load_i      (reg_load[i]),
      .clear_i     (reg_clear[i]),
      .status_o    (status[i*STS_W +: STS_W]),
      .count_o     (count[i*CNT_W +: CNT_W]),
      .pending_n_o (pend_n[i])
    );
  end

  // Pending flags are flops, so the reduction is glitch-free; the mask is a
  // static register level and gates the reduction directly.
`ifdef WTS_TIMER_MASK_EN
  assign nint = &(pend_n | reg_int_mask);
`else
  assign nint = &pend_n;
`endif

endmodule

// File: tb/tb_wts_timer_multi.sv
// Bench for wts_timer_multi: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the timer channels.
module tb_wts_timer_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 12;
  localparam int ADDR_W = 2;

  logic                     clk = 1'b0;
  logic                     nreset = 1'b0;
  logic                     tick = 1'b0;
  logic [NUM_CH-1:0]        event_trigger = '0;
  logic [NUM_CH*ADDR_W-1:0] event_address = '0;
  logic [NUM_CH-1:0]        reg_enable = '0;
  logic [2*NUM_CH-1:0]      reg_mode = '0;
  logic [NUM_CH*CNT_W-1:0]  reg_reload = '0;
  logic [NUM_CH-1:0]        reg_load = '0;
  logic [NUM_CH-1:0]        reg_clear = '0;
`ifdef WTS_TIMER_MASK_EN
  logic [NUM_CH-1:0]        reg_int_mask = '0;
`endif
  logic [8*NUM_CH-1:0]      status;
  logic [NUM_CH*CNT_W-1:0]  count;
  logic                     nint;

  always #5 clk = ~clk;

  wts_timer_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .tick          (tick),
    .event_trigger (event_trigger),
    .event_address (event_address),
    .reg_enable    (reg_enable),
    .reg_mode      (reg_mode),
    .reg_reload    (reg_reload),
    .reg_load      (reg_load),
    .reg_clear     (reg_clear),
`ifdef WTS_TIMER_MASK_EN
    .reg_int_mask  (reg_int_mask),
`endif
    .status        (status),
    .count         (count),
    .nint          (nint)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-channel pending/overflow/address plus the number of
  // ticks remaining and whether the countdown is armed.
  bit m_pend_n [NUM_CH];
  bit m_ovf    [NUM_CH];
  int m_addr   [NUM_CH];
  int m_cnt    [NUM_CH];
  bit m_run    [NUM_CH];

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend_n[i] = 1'b1;
      m_ovf[i]    = 1'b0;
      m_addr[i]   = 0;
      m_cnt[i]    = 0;
      m_run[i]    = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      int mode   = int'(reg_mode[2*i +: 2]);
      int rl     = int'(reg_reload[i*CNT_W +: CNT_W]);
      bit en     = reg_enable[i];
      bit counts = en && (mode == 1 || mode == 2);
      bit fire   = 1'b0;
      if (reg_load[i]) begin
        m_cnt[i] = rl;
        m_run[i] = (rl != 0);
      end else if (counts && tick && m_run[i] && m_cnt[i] > 0) begin
        m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0) begin
          fire = 1'b1;
          if (mode == 2) m_cnt[i] = rl;
          else           m_run[i] = 1'b0;
        end
      end
      if (en && mode == 0 && event_trigger[i]) fire = 1'b1;
      if (reg_clear[i]) begin
        m_pend_n[i] = 1'b1;
        m_ovf[i]    = 1'b0;
      end else if (fire) begin
        if (!m_pend_n[i]) m_ovf[i] = 1'b1;
        m_pend_n[i] = 1'b0;
        m_addr[i]   = int'(event_address[i*ADDR_W +: ADDR_W]);
      end
    end
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) model_reset();
    else         model_step();
  end

  function automatic bit masked(input int i);
`ifdef WTS_TIMER_MASK_EN
    return reg_int_mask[i];
`else
    return 1'b0;
`endif
  endfunction

  // Single compare process, sampling 2 time units after the active edge.
  always begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      logic exp_nint;
      exp_nint = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        logic [7:0] exp_sts;
        exp_sts    = 8'(m_addr[i]);
        exp_sts[7] = m_pend_n[i];
        exp_sts[6] = m_ovf[i];
        check($sformatf("model_status%0d", i), 32'(status[8*i +: 8]), 32'(exp_sts));
        check($sformatf("model_count%0d", i), 32'(count[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
        if (!m_pend_n[i] && !masked(i)) exp_nint = 1'b0;
      end
      check("model_nint", 32'(nint), 32'(exp_nint));
    end
  end

  // Advance one cycle; inputs change only on the falling edge.
  task automatic cyc();
    @(negedge clk);
    tick          = 1'b0;
    event_trigger = '0;
    reg_load      = '0;
    reg_clear     = '0;
  endtask

  int exp_per [7] = '{2, 1, 3, 2, 1, 3, 2};

  initial begin
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    chk_en = 1'b1;
    cyc();
    check("reset_status", 32'(status), 32'h8080);
    check("reset_count", 32'(count), 32'h0);
    check("reset_nint", 32'(nint), 32'h1);

    // Event mode on channel 0.
    reg_mode      = 4'b0000;
    reg_enable    = 2'b01;
    event_address = 4'b0010;
    event_trigger = 2'b01;
    cyc();
    check("event_status0", 32'(status[7:0]), 32'h02);
    check("event_nint", 32'(nint), 32'h0);
    reg_clear = 2'b01;
    cyc();
    check("clear_status0", 32'(status[7:0]), 32'h82);
    check("clear_nint", 32'(nint), 32'h1);

    // Periodic on channel 1, reload 3, seven ticks.
    reg_mode              = 4'b1000;
    reg_enable            = 2'b11;
    reg_reload[23:12]     = 12'd3;
    event_address         = 4'b0110;
    reg_load              = 2'b10;
    cyc();
    check("per_load_count1", 32'(count[23:12]), 32'd3);
    for (int k = 0; k < 7; k++) begin
      tick = 1'b1;
      cyc();
      check($sformatf("per_count1_t%0d", k + 1), 32'(count[23:12]), 32'(exp_per[k]));
      if (k == 2) begin
        check("per_fire1_status1", 32'(status[15:8]), 32'h01);
        check("per_fire1_nint", 32'(nint), 32'h0);
      end
      if (k == 5) check("per_ovf_status1", 32'(status[15:8]), 32'h41);
    end

    // One-shot on channel 0, reload 2, five ticks.
    reg_mode          = 4'b1001;
    reg_reload[11:0]  = 12'd2;
    event_address     = 4'b0111;
    reg_load          = 2'b01;
    cyc();
    check("os_load_count0", 32'(count[11:0]), 32'd2);
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1;
      cyc();
      check($sformatf("os_count0_t%0d", k + 1), 32'(count[11:0]), (k == 0) ? 32'd1 : 32'd0);
      check($sformatf("os_status0_t%0d", k + 1), 32'(status[7:0]), (k == 0) ? 32'h82 : 32'h03);
    end
    reg_reload[11:0] = 12'd0;
    reg_clear        = 2'b01;
    reg_load         = 2'b01;
    cyc();
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      cyc();
    end
    check("os_zero_count0", 32'(count[11:0]), 32'd0);
    check("os_zero_status0", 32'(status[7:0]), 32'h83);

    // Load and tick together on channel 1.
    reg_clear = 2'b10;
    cyc();
    reg_reload[23:12] = 12'd5;
    reg_load          = 2'b10;
    tick              = 1'b1;
    cyc();
    check("loadtick_count1", 32'(count[23:12]), 32'd5);
    check("loadtick_status1", 32'(status[15:8]), 32'h81);
    repeat (2) begin
      tick = 1'b1;
      cyc();
    end
    check("run_count1", 32'(count[23:12]), 32'd3);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    check("async_status", 32'(status), 32'h8080);
    check("async_count", 32'(count), 32'h0);
    check("async_nint", 32'(nint), 32'h1);
    @(negedge clk);
    nreset = 1'b1;

    // Clear and fire in the same cycle: clear wins.
    reg_mode      = 4'b0000;
    reg_enable    = 2'b11;
    event_address = 4'b0101;
    event_trigger = 2'b01;
    reg_clear     = 2'b01;
    cyc();
    check("clrfire_status0", 32'(status[7:0]), 32'h80);
    check("clrfire_nint", 32'(nint), 32'h1);

`ifdef WTS_TIMER_MASK_EN
    reg_int_mask  = 2'b10;
    event_trigger = 2'b10;
    cyc();
    check("mask_status1", 32'(status[15:8]), 32'h01);
    check("mask_nint", 32'(nint), 32'h1);
    reg_int_mask = 2'b00;
    #1;
    check("unmask_nint", 32'(nint), 32'h0);
    reg_clear = 2'b10;
    cyc();
`endif

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      tick          = 1'($urandom_range(0, 1));
      event_address = NUM_CH*ADDR_W'($urandom);
      for (int i = 0; i < NUM_CH; i++) begin
        event_trigger[i] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) reg_mode[2*i +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) reg_enable[i] = ~reg_enable[i];
        if ($urandom_range(0, 7) == 0) reg_reload[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
        reg_load[i]  = ($urandom_range(0, 11) == 0);
        reg_clear[i] = ($urandom_range(0, 9) == 0);
`ifdef WTS_TIMER_MASK_EN
        if ($urandom_range(0, 15) == 0) reg_int_mask[i] = ~reg_int_mask[i];
`endif
      end
      cyc();
    end

    @(posedge clk);
    #3;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
